// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//  - lsu_state_e : control FSM states
//  - F3*         : RV32I load/store funct3 encodings
//  - lane_mask / store_lanes / is_misaligned / is_illegal : request decode helpers
package lsu_pkg;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} lsu_state_e;

   localparam logic [2:0] F3B  = 3'b000;
   localparam logic [2:0] F3H  = 3'b001;
   localparam logic [2:0] F3W  = 3'b010;
   localparam logic [2:0] F3Bu = 3'b100;
   localparam logic [2:0] F3Hu = 3'b101;

   // Byte-lane write mask for a store of the given width at the given byte offset.
   function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
      case (funct3)
         F3B:     lane_mask = 4'b0001 << offset;
         F3H:     lane_mask = 4'b0011 << {offset[1], 1'b0};
         F3W:     lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   // Replicate right-justified store data into every lane it could land in.
   function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] d);
      case (funct3)
         F3B:     store_lanes = {4{d[7:0]}};
         F3H:     store_lanes = {2{d[15:0]}};
         default: store_lanes = d;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      case (funct3)
         F3H, F3Hu: is_misaligned = offset[0];
         F3W:       is_misaligned = |offset;
         default:   is_misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
      if (we) begin
         is_illegal = !(funct3 == F3B || funct3 == F3H || funct3 == F3W);
      end else begin
         is_illegal = !(funct3 == F3B || funct3 == F3H || funct3 == F3W ||
                        funct3 == F3Bu || funct3 == F3Hu);
      end
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: selects the addressed byte/halfword of a memory word
// and sign- or zero-extends it to 32 bits.
//  rdata_i  in  32  raw memory word
//  offset_i in  2   byte offset within the word
//  funct3_i in  3   load funct3
//  ext_o    out 32  extended load value (0 for non-load encodings)
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] ext_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (funct3_i)
         F3B:     ext_o = {{24{byte_sel[7]}}, byte_sel};
         F3Bu:    ext_o = {24'b0, byte_sel};
         F3H:     ext_o = {{16{half_sel[15]}}, half_sel};
         F3Hu:    ext_o = {16'b0, half_sel};
         F3W:     ext_o = rdata_i;
         default: ext_o = '0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Core-side load/store unit driving the data-memory port.
// Accepts one RV32I load/store at a time, lane-aligns stores, waits out the memory's
// registered read for loads, and flags misaligned/illegal requests without a memory access.
//  clk, rst                    clock; asynchronous active-high reset
//  req_valid_i / req_ready_o   request handshake (ready only while idle)
//  req_we_i, req_funct3_i      store flag and RV32I funct3
//  req_addr_i, req_wdata_i     byte address, right-justified store data
//  rsp_valid_o                 one-cycle response pulse
//  rsp_rdata_o, rsp_err_o      extended load data (0 for stores/errors), error flag
//  mem_addr_o                  word-aligned memory address
//  mem_we_o, mem_re_o          memory write/read enables (single ISSUE cycle)
//  mem_W_data_o, mem_W_mask_o  lane-replicated store data and byte mask
//  mem_R_data_i                read data, valid the cycle after mem_re_o
module lsu
   import lsu_pkg::*;
#(
   parameter bit MISALIGN_TRAP = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic        mem_re_o,
   output logic [31:0] mem_W_data_o,
   output logic [3:0]  mem_W_mask_o,
   input  logic [31:0] mem_R_data_i
);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        accept;
   logic        req_err;
   logic [31:0] addr_fix;
   logic [31:0] load_ext;

   lsu_load_align u_load_align (
      .rdata_i  (mem_R_data_i),
      .offset_i (addr_q[1:0]),
      .funct3_i (funct3_q),
      .ext_o    (load_ext)
   );

   always_comb begin
      accept  = req_valid_i && (state_q == StIdle);
      req_err = is_illegal(req_we_i, req_funct3_i) ||
                (MISALIGN_TRAP && is_misaligned(req_funct3_i, req_addr_i[1:0]));

      // With trapping disabled, misaligned offsets are rounded down to the access size.
      // When trapping is enabled such requests never reach memory, so this is harmless.
      addr_fix = req_addr_i;
      case (req_funct3_i)
         F3H, F3Hu: addr_fix[0]   = 1'b0;
         F3W:       addr_fix[1:0] = 2'b00;
         default:   ;
      endcase

      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               we_d     = req_we_i;
               funct3_d = req_funct3_i;
               addr_d   = addr_fix;
               wdata_d  = req_wdata_i;
               rdata_d  = '0;
               err_d    = req_err;
               state_d  = req_err ? StResp : StIssue;
            end
         end
         StIssue: state_d = we_q ? StResp : StWait;
         StWait: begin
            rdata_d = load_ext;
            state_d = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      req_ready_o  = (state_q == StIdle);
      mem_we_o     = (state_q == StIssue) && we_q;
      mem_re_o     = (state_q == StIssue) && !we_q;
      mem_addr_o   = {addr_q[31:2], 2'b00};
      mem_W_data_o = store_lanes(funct3_q, wdata_q);
      mem_W_mask_o = mem_we_o ? lane_mask(funct3_q, addr_q[1:0]) : 4'b0000;
      rsp_valid_o  = (state_q == StResp);
      rsp_err_o    = rsp_valid_o && err_q;
      rsp_rdata_o  = rdata_q;
   end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re;
   logic [3:0]  mem_mask;

   // Second instance with misalignment trapping disabled.
   logic        nt_valid, nt_ready, nt_rsp_valid, nt_rsp_err, nt_mem_we, nt_mem_re;
   logic [31:0] nt_rsp_rdata, nt_mem_addr, nt_mem_wdata, nt_mem_rdata;
   logic [3:0]  nt_mem_mask;

   int n_vec = 0;
   int n_fail = 0;
   int cyc = 0;
   int en_cnt = 0;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb_q[$];

   logic [31:0] mem [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu #(.MISALIGN_TRAP(1'b1)) u_dut (
      .clk (clk), .rst (rst),
      .req_valid_i (req_valid), .req_ready_o (req_ready), .req_we_i (req_we),
      .req_funct3_i (req_funct3), .req_addr_i (req_addr), .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid), .rsp_rdata_o (rsp_rdata), .rsp_err_o (rsp_err),
      .mem_addr_o (mem_addr), .mem_we_o (mem_we), .mem_re_o (mem_re),
      .mem_W_data_o (mem_wdata), .mem_W_mask_o (mem_mask), .mem_R_data_i (mem_rdata)
   );

   lsu #(.MISALIGN_TRAP(1'b0)) u_dut_nt (
      .clk (clk), .rst (rst),
      .req_valid_i (nt_valid), .req_ready_o (nt_ready), .req_we_i (req_we),
      .req_funct3_i (req_funct3), .req_addr_i (req_addr), .req_wdata_i (req_wdata),
      .rsp_valid_o (nt_rsp_valid), .rsp_rdata_o (nt_rsp_rdata), .rsp_err_o (nt_rsp_err),
      .mem_addr_o (nt_mem_addr), .mem_we_o (nt_mem_we), .mem_re_o (nt_mem_re),
      .mem_W_data_o (nt_mem_wdata), .mem_W_mask_o (nt_mem_mask),
      .mem_R_data_i (nt_mem_rdata)
   );

   // d_mem model: 16 words, registered read, out-of-range reads return 0xAAAAAAAA.
   initial for (int i = 0; i < 16; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (mem_we && mem_addr < 32'd64)
         for (int i = 0; i < 4; i++)
            if (mem_mask[i]) mem[mem_addr[5:2]][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      if (mem_re) mem_rdata <= (mem_addr < 32'd64) ? mem[mem_addr[5:2]] : 32'hAAAAAAAA;
   end

   // Fixed memory for the non-trapping instance: only word 0x20 is populated.
   always @(posedge clk)
      if (nt_mem_re) nt_mem_rdata <= (nt_mem_addr == 32'h20) ? 32'h8081F0F1 : 32'hAAAAAAAA;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every response and checks port invariants.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we || mem_re) begin
            en_cnt++;
            chk("enables_exclusive", {31'b0, mem_we & mem_re}, 32'd0);
            if (mem_re) chk("load_mask_zero", {28'b0, mem_mask}, 32'd0);
         end
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL spurious_rsp: got rsp_valid=1, expected no response");
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
               chk({e.name, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
               chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   // Presents a request; returns #1 after the accepting edge (the ISSUE cycle for good requests).
   task automatic issue(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit hold,
                        output int acc_cyc);
      int n;
      int lat;
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      acc_cyc = cyc;
      if (!req_ready) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s_accept: got req_ready=0 for 20 cycles, expected 1", name);
         req_valid = 1'b0;
         return;
      end
      lat = exp_err ? 1 : (we ? 2 : 3);
      sb_q.push_back('{name, exp_rdata, exp_err, cyc + lat});
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain: got %0d responses missing, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic nt_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_rdata);
      int n = 0;
      @(negedge clk);
      req_we = 1'b0; req_funct3 = f3; req_addr = addr; nt_valid = 1'b1;
      @(posedge clk);
      #1;
      nt_valid = 1'b0;
      chk({name, "_re"}, {31'b0, nt_mem_re}, 32'd1);
      chk({name, "_addr"}, nt_mem_addr, 32'h20);
      while (!nt_rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_valid"}, {31'b0, nt_rsp_valid}, 32'd1);
      chk({name, "_rdata"}, nt_rsp_rdata, exp_rdata);
      chk({name, "_err"}, {31'b0, nt_rsp_err}, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected completion");
      $fatal(1);
   end

   initial begin
      int t1, t2, en0;
      rst = 1'b1; req_valid = 1'b0; nt_valid = 1'b0;
      req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      #12;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_mask", {28'b0, mem_mask}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      issue("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, t1);
      chk("sw_we", {31'b0, mem_we}, 32'd1);
      chk("sw_re", {31'b0, mem_re}, 32'd0);
      chk("sw_mask", {28'b0, mem_mask}, 32'hF);
      chk("sw_addr", mem_addr, 32'h10);
      chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
      drain();

      issue("sb_13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 1'b0, t1);
      chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
      chk("sb_mask", {28'b0, mem_mask}, 32'h8);
      chk("sb_addr", mem_addr, 32'h10);
      drain();

      issue("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b0, t1);
      chk("lw_re", {31'b0, mem_re}, 32'd1);
      chk("lw_we", {31'b0, mem_we}, 32'd0);
      drain();

      issue("sh_12", 1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, 1'b0, t1);
      chk("sh_wdata", mem_wdata, 32'h12341234);
      chk("sh_mask", {28'b0, mem_mask}, 32'hC);
      drain();
      issue("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 1'b0, t1);
      drain();

      issue("sw_20", 1'b1, 3'b010, 32'h20, 32'h8081F0F1, 32'h0, 1'b0, 1'b0, t1);
      drain();
      issue("lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFF0, 1'b0, 1'b0, t1);
      drain();
      issue("lbu_21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h000000F0, 1'b0, 1'b0, t1);
      drain();
      issue("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8081, 1'b0, 1'b0, t1);
      drain();
      issue("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008081, 1'b0, 1'b0, t1);
      drain();
      issue("lb_23", 1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, t1);
      drain();
      issue("lh_20", 1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFFF0F1, 1'b0, 1'b0, t1);
      drain();
      issue("lw_oor", 1'b0, 3'b010, 32'h100, 32'h0, 32'hAAAAAAAA, 1'b0, 1'b0, t1);
      drain();
      issue("lb_oor", 1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0, t1);
      drain();

      en0 = en_cnt;
      issue("err_lw_22", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1'b0, t1);
      drain();
      issue("err_lh_21", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 1'b0, t1);
      drain();
      issue("err_ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, t1);
      drain();
      issue("err_st_f3_100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, t1);
      drain();
      issue("err_sw_11", 1'b1, 3'b010, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, t1);
      drain();
      chk("err_no_mem_access", 32'(en_cnt), 32'(en0));
      issue("lw_10_after_err", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 1'b0, t1);
      drain();

      // Back-to-back: valid held, second request waits until the first has responded.
      issue("b2b_lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h8081F0F1, 1'b0, 1'b1, t1);
      issue("b2b_lbu_23", 1'b0, 3'b100, 32'h23, 32'h0, 32'h00000080, 1'b0, 1'b0, t2);
      chk("b2b_accept_gap", 32'(t2 - t1), 32'd4);
      drain();

      // Reset while the load sits in WAIT: no response may follow.
      issue("rst_lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h8081F0F1, 1'b0, 1'b0, t1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      sb_q.delete();
      #1;
      chk("midrst_ready", {31'b0, req_ready}, 32'd1);
      chk("midrst_re", {31'b0, mem_re}, 32'd0);
      chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      issue("post_rst_lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 1'b0, t1);
      drain();

      nt_load("nt_lw_22", 3'b010, 32'h22, 32'h8081F0F1);
      nt_load("nt_lh_21", 3'b001, 32'h21, 32'hFFFFF0F1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
